// File: rtl/fsk_pkg.sv
// ---------------------------------------------------------------------------
// fsk_pkg
// Shared definitions for the FSK bitstreamer / bitreceiver pair.
//   tx_state_e  : one-hot states of the transmit-side streamer
//   rx_state_e  : one-hot states of the receive-side bit receiver
//   fsk_thresh  : low-width decision threshold between bit 0 and bit 1
//   fsk_clog2   : ceil(log2(value)), minimum 1, for counter sizing
// ---------------------------------------------------------------------------
package fsk_pkg;

    typedef enum logic [2:0] {
        TX_IDLE = 3'b001,
        TX_SEND = 3'b010,
        TX_DONE = 3'b100
    } tx_state_e;

    typedef enum logic [4:0] {
        RX_IDLE     = 5'b00001,
        RX_WAITFALL = 5'b00010,
        RX_LOWCNT   = 5'b00100,
        RX_STORE    = 5'b01000,
        RX_DONE     = 5'b10000
    } rx_state_e;

    // A bit-0 low pulse lasts CLK_DIV1/2 cycles, a bit-1 pulse CLK_DIV2/2;
    // the midpoint of the two half-periods is (CLK_DIV1+CLK_DIV2)/4.
    function automatic int fsk_thresh(input int clk_div1, input int clk_div2);
        return (clk_div1 + clk_div2) >> 2;
    endfunction

    function automatic int fsk_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fsk_sync_edge.sv
// ---------------------------------------------------------------------------
// fsk_sync_edge
// Brings the asynchronous FSK line into the clk domain and flags its edges.
//   clk     in  system clock
//   rst     in  synchronous, active-high reset (all flops to 0)
//   rx_i    in  asynchronous line
//   rx_s_o  out synchronized line (second synchronizer flop)
//   rise_o  out rx_s went 0->1 this cycle
//   fall_o  out rx_s went 1->0 this cycle
// ---------------------------------------------------------------------------
module fsk_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // NOTE: state is updated with <= so every flop samples the pre-edge
    // value of its source; '=' here would collapse the chain into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign rise_o = ~dly_q & sync_q;
    assign fall_o = dly_q & ~sync_q;

endmodule

// File: rtl/fsk_bitreceiver.sv
// ---------------------------------------------------------------------------
// fsk_bitreceiver
// Decodes an FSK bit stream in which every bit is one square-wave period and
// the width of its low pulse carries the value (short = 0, long = 1). DATALEN
// bits are collected LSB first into a parallel word.
//   clk        in  system clock
//   rst        in  synchronous, active-high reset
//   start      in  arms reception (sampled only while idle)
//   rxin       in  asynchronous FSK line
//   busy       out high from arming until the frame completes or times out
//   bitstrobe  out one-cycle pulse per decoded bit
//   bitval     out value of the last decoded bit
//   dataout    out received word, bit 0 = first bit received
//   valid      out one-cycle pulse, coincident with the new dataout
//   err        out one-cycle pulse on an idle or low-width timeout
// ---------------------------------------------------------------------------
module fsk_bitreceiver
    import fsk_pkg::*;
#(
    parameter int DATALEN  = 64,
    parameter int CNTLEN   = 8,
    parameter int CLK_DIV1 = 16,
    parameter int CLK_DIV2 = 32,
    parameter int MIN_LOW  = 3,
    parameter int TIMEOUT  = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               rxin,
    output logic               busy,
    output logic               bitstrobe,
    output logic               bitval,
    output logic [DATALEN-1:0] dataout,
    output logic               valid,
    output logic               err
);

    localparam int                BCW       = fsk_clog2(DATALEN + 1);
    localparam logic [CNTLEN-1:0] THRESH_C  = CNTLEN'(fsk_thresh(CLK_DIV1, CLK_DIV2));
    localparam logic [CNTLEN-1:0] MIN_LOW_C = CNTLEN'(MIN_LOW);
    localparam logic [CNTLEN-1:0] TIMEOUT_C = CNTLEN'(TIMEOUT);
    localparam logic [CNTLEN-1:0] ONE_C     = CNTLEN'(1);
    localparam logic [BCW-1:0]    LAST_C    = BCW'(DATALEN - 1);

    logic rx_s;
    logic rise;
    logic fall;

    fsk_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rxin),
        .rx_s_o (rx_s),
        .rise_o (rise),
        .fall_o (fall)
    );

    rx_state_e          state_q,   state_d;
    logic [BCW-1:0]     bitcnt_q,  bitcnt_d;
    logic [CNTLEN-1:0]  idlecnt_q, idlecnt_d;
    logic [CNTLEN-1:0]  lowcnt_q,  lowcnt_d;
    logic [DATALEN-1:0] shreg_q,   shreg_d;
    logic [DATALEN-1:0] dataout_q, dataout_d;
    logic               bit_q,     bit_d;
    logic               busy_q,    busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            bitcnt_q  <= '0;
            idlecnt_q <= '0;
            lowcnt_q  <= '0;
            shreg_q   <= '0;
            dataout_q <= '0;
            bit_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            idlecnt_q <= idlecnt_d;
            lowcnt_q  <= lowcnt_d;
            shreg_q   <= shreg_d;
            dataout_q <= dataout_d;
            bit_q     <= bit_d;
            busy_q    <= busy_d;
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        idlecnt_d = idlecnt_q;
        lowcnt_d  = lowcnt_q;
        shreg_d   = shreg_q;
        dataout_d = dataout_q;
        bit_d     = bit_q;
        busy_d    = busy_q;
        bitstrobe = 1'b0;
        valid     = 1'b0;
        err       = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (start) begin
                    bitcnt_d  = '0;
                    idlecnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = RX_WAITFALL;
                end
            end

            RX_WAITFALL: begin
                // The idle timeout only runs once the first bit has landed.
                if (bitcnt_q != '0 && idlecnt_q != TIMEOUT_C) begin
                    idlecnt_d = idlecnt_q + ONE_C;
                end
                if (fall) begin
                    lowcnt_d = ONE_C;
                    state_d  = RX_LOWCNT;
                end else if (idlecnt_q == TIMEOUT_C) begin
                    err     = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RX_IDLE;
                end
            end

            RX_LOWCNT: begin
                // lowcnt equals the number of low cycles on rx_s when the
                // rise is seen: the fall cycle loads 1, each later low adds 1.
                if (rise) begin
                    if (lowcnt_q < MIN_LOW_C) begin
                        state_d = RX_WAITFALL;
                    end else begin
                        bit_d   = (lowcnt_q >= THRESH_C);
                        state_d = RX_STORE;
                    end
                end else if (lowcnt_q == TIMEOUT_C) begin
                    err     = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RX_IDLE;
                end else if (!rx_s) begin
                    lowcnt_d = lowcnt_q + ONE_C;
                end
            end

            RX_STORE: begin
                shreg_d   = {bit_q, shreg_q[DATALEN-1:1]};
                bitstrobe = 1'b1;
                bitcnt_d  = bitcnt_q + 1'b1;
                idlecnt_d = '0;
                if (bitcnt_q == LAST_C) begin
                    // Load the word here so it is already on dataout while
                    // valid is asserted in DONE.
                    dataout_d = shreg_d;
                    state_d   = RX_DONE;
                end else if (fall) begin
                    // With a single high cycle between bits the next fall
                    // coincides with this cycle; start measuring it now.
                    lowcnt_d = ONE_C;
                    state_d  = RX_LOWCNT;
                end else begin
                    state_d = RX_WAITFALL;
                end
            end

            RX_DONE: begin
                valid   = 1'b1;
                busy_d  = 1'b0;
                state_d = RX_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = RX_IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign bitval  = bit_q;
    assign dataout = dataout_q;

endmodule
